// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing, coordinate type and the 8-bar colour table.
// The colour table is used only when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

  // {red, green, blue} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam int TP_BAR_W = 80;
  localparam logic [2:0] TP_BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                            3'b101, 3'b100, 3'b001, 3'b000};

  function automatic logic [2:0] tp_bar_rgb(input coord_t x);
    logic [2:0] rgb;
    rgb = TP_BAR_RGB[0];
    for (int i = 1; i < 8; i++)
      if (x >= coord_t'(i * TP_BAR_W)) rgb = TP_BAR_RGB[i];
    return rgb;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Parameterised shift register that delays the raw {hs,vs} pair; DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = vga_clk ^ reset;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_p[i] <= RESET_VAL;
      end else begin
        stage_p[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
    end

    assign q = stage_p[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: DrawX/DrawY, blank, delayed hs/vs, vblank pulse and frame counter.
// Defining VGA_TEST_PATTERN_EN adds registered 8-bar colour outputs tp_red/tp_green/tp_blue.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  output coord_t      DrawX,
  output coord_t      DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        vblank_pulse,
  output logic [15:0] frame_count
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [3:0]  tp_red,
  output logic [3:0]  tp_green,
  output logic [3:0]  tp_blue
`endif
);

  localparam int G_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int G_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (G_H_TOTAL > 1024) begin : g_bad_h
    $error("H_TOTAL does not fit the 10-bit horizontal counter");
  end
  if (G_V_TOTAL > 1024) begin : g_bad_v
    $error("V_TOTAL does not fit the 10-bit vertical counter");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("SYNC_DELAY must be 0..4");
  end

  localparam coord_t H_LAST   = coord_t'(G_H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(G_V_TOTAL - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t V_PRE_VB = coord_t'(V_VISIBLE - 1);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t     hc, vc;
  logic       run;
  logic       hs_raw, vs_raw;
  logic [1:0] sync_q;

  // run rises on the first edge out of reset, so pixel (0,0) is held one extra clock
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      run          <= 1'b0;
      hc           <= '0;
      vc           <= '0;
      frame_count  <= '0;
      vblank_pulse <= 1'b0;
    end else begin
      run          <= 1'b1;
      vblank_pulse <= run && (hc == H_LAST) && (vc == V_PRE_VB);
      if (run) begin
        if (hc == H_LAST) begin
          hc <= '0;
          if (vc == V_LAST) begin
            vc          <= '0;
            frame_count <= frame_count + 16'd1;
          end else begin
            vc <= vc + coord_t'(1);
          end
        end else begin
          hc <= hc + coord_t'(1);
        end
      end
    end
  end

  assign DrawX  = hc;
  assign DrawY  = vc;
  assign blank  = run && (hc < H_VIS_C) && (vc < V_VIS_C);
  assign hs_raw = !(run && (hc >= HS_FIRST) && (hc <= HS_LAST));
  assign vs_raw = !(run && (vc >= VS_FIRST) && (vc <= VS_LAST));

  // syncs delayed to match the renderers' registered colour output
  sync_delay_line #(
    .WIDTH    (2),
    .DEPTH    (SYNC_DELAY),
    .RESET_VAL(2'b11)
  ) u_sync_delay (
    .vga_clk(vga_clk),
    .reset  (reset),
    .d      ({hs_raw, vs_raw}),
    .q      (sync_q)
  );

  assign {hs, vs} = sync_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_rgb;
  assign bar_rgb = tp_bar_rgb(hc);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      tp_red   <= '0;
      tp_green <= '0;
      tp_blue  <= '0;
    end else begin
      tp_red   <= (blank && bar_rgb[2]) ? 4'hF : 4'h0;
      tp_green <= (blank && bar_rgb[1]) ? 4'hF : 4'h0;
      tp_blue  <= (blank && bar_rgb[0]) ? 4'hF : 4'h0;
    end
  end
`endif

endmodule
